// File: rtl/yuv422_conv_seq.sv
// YUYV-to-RGB job sequencer: reads packed 4:2:2 words, feeds an external
// converter one pixel at a time and writes RGB pixels to destination memory.
module yuv422_conv_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] num_pixels,
    input  logic [15:0] src_base,
    input  logic [15:0] dst_base,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        src_rd,
    output logic [15:0] src_addr,
    input  logic [31:0] src_rdata,
    output logic        conv_start,
    output logic [7:0]  conv_y,
    output logic [7:0]  conv_u,
    output logic [7:0]  conv_v,
    input  logic        conv_ready,
    input  logic [7:0]  conv_r,
    input  logic [7:0]  conv_g,
    input  logic [7:0]  conv_b,
    output logic        dst_wr,
    output logic [15:0] dst_addr,
    output logic [23:0] dst_wdata,
    input  logic        dst_ready
);

    typedef enum logic [3:0] {
        IDLE, RD, RDW, CONV0, WAIT0, WR0, CONV1, WAIT1, WR1, DONE
    } state_t;

    state_t      state;
    logic [14:0] words;
    logic [14:0] idx;
    logic [15:0] sbase;
    logic [15:0] dbase;
    logic [7:0]  y1;
    logic [14:0] idx_nxt;
    logic        job_ok;

    // 15-bit index: a full 0xFFFE-pixel job needs at most 0x7FFF words
    assign idx_nxt = idx + 15'd1;
    assign job_ok  = (num_pixels != 16'd0) && !num_pixels[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            words      <= '0;
            idx        <= '0;
            sbase      <= '0;
            dbase      <= '0;
            y1         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            src_rd     <= 1'b0;
            src_addr   <= '0;
            conv_start <= 1'b0;
            conv_y     <= '0;
            conv_u     <= '0;
            conv_v     <= '0;
            dst_wr     <= 1'b0;
            dst_addr   <= '0;
            dst_wdata  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort && state != IDLE) begin
                state      <= IDLE;
                busy       <= 1'b0;
                src_rd     <= 1'b0;
                conv_start <= 1'b0;
                dst_wr     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            if (job_ok) begin
                                words    <= num_pixels[15:1];
                                sbase    <= src_base;
                                dbase    <= dst_base;
                                idx      <= '0;
                                busy     <= 1'b1;
                                src_rd   <= 1'b1;
                                src_addr <= src_base;
                                state    <= RD;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                    RD: begin
                        src_rd <= 1'b0;
                        state  <= RDW;
                    end
                    RDW: begin
                        y1         <= src_rdata[23:16];
                        conv_y     <= src_rdata[7:0];
                        conv_u     <= src_rdata[15:8];
                        conv_v     <= src_rdata[31:24];
                        conv_start <= 1'b1;
                        state      <= CONV0;
                    end
                    CONV0: begin
                        conv_start <= 1'b0;
                        state      <= WAIT0;
                    end
                    WAIT0: begin
                        if (conv_ready) begin
                            dst_wdata <= {conv_r, conv_g, conv_b};
                            dst_addr  <= dbase + {idx, 1'b0};
                            dst_wr    <= 1'b1;
                            state     <= WR0;
                        end
                    end
                    WR0: begin
                        if (dst_ready) begin
                            dst_wr     <= 1'b0;
                            conv_y     <= y1;
                            conv_start <= 1'b1;
                            state      <= CONV1;
                        end
                    end
                    CONV1: begin
                        conv_start <= 1'b0;
                        state      <= WAIT1;
                    end
                    WAIT1: begin
                        if (conv_ready) begin
                            dst_wdata <= {conv_r, conv_g, conv_b};
                            dst_addr  <= dbase + {idx, 1'b1};
                            dst_wr    <= 1'b1;
                            state     <= WR1;
                        end
                    end
                    WR1: begin
                        if (dst_ready) begin
                            dst_wr <= 1'b0;
                            if (idx_nxt < words) begin
                                idx      <= idx_nxt;
                                src_rd   <= 1'b1;
                                src_addr <= sbase + {1'b0, idx_nxt};
                                state    <= RD;
                            end else begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/yuv422_conv_seq.md
YUV422_CONV_SEQ -- requirements
Module: yuv422_conv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, system clock (same as APB clock); rst_n input 1, asynchronous reset, active low (same as APB reset).
REQ-002 The block SHALL have these control ports: start input 1, pulse that starts a job; num_pixels input 16, pixels in the job; src_base input 16, source word base address; dst_base input 16, destination pixel base address; abort input 1, cancels the job; busy output 1, job in progress; done output 1, one-cycle pulse at job end; err output 1, one-cycle pulse when start is rejected.
REQ-003 The block SHALL have these source-memory ports: src_rd output 1, read strobe; src_addr output 16, word address; src_rdata input 32, packed YUYV word {V,Y1,U,Y0}, valid exactly 1 cycle after src_rd.
REQ-004 The block SHALL have these converter ports: conv_start output 1, drives start_conversion; conv_y, conv_u, conv_v output 8 each, YUV to the converter; conv_ready input 1, converter pixel_ready; conv_r, conv_g, conv_b input 8 each, converter RGB, valid while conv_ready=1.
REQ-005 The block SHALL have these destination ports: dst_wr output 1, write request; dst_addr output 16, pixel address; dst_wdata output 24, {R,G,B}; dst_ready input 1, the write is accepted on a cycle where dst_wr=1 and dst_ready=1.

Function
REQ-006 FSM states SHALL be IDLE, RD, RDW, CONV0, WAIT0, WR0, CONV1, WAIT1, WR1, DONE.
REQ-007 In IDLE, start=1 with num_pixels nonzero and even SHALL latch num_pixels/2 as the word count and both bases, clear the word index, and go to RD; busy SHALL be 1 in every state except IDLE.
REQ-008 In IDLE, start=1 with num_pixels zero or odd SHALL pulse err for 1 cycle and stay in IDLE; start SHALL be ignored while busy=1.
REQ-009 RD SHALL assert src_rd=1 for 1 cycle with src_addr = src_base + index (mod 2^16), then go to RDW; RDW SHALL capture src_rdata into a word register and go to CONV0.
REQ-010 CONV0 SHALL assert conv_start=1 for exactly 1 cycle with conv_y=Y0 (bits 7:0), conv_u=U (bits 15:8), conv_v=V (bits 31:24), then go to WAIT0.
REQ-011 CONV1 SHALL do the same as CONV0 with conv_y=Y1 (bits 23:16) and the same U and V (4:2:2 chroma sharing).
REQ-012 conv_y, conv_u and conv_v SHALL hold their values from the CONV cycle until conv_ready is seen.
REQ-013 WAITn SHALL wait any number of cycles for conv_ready=1, capture {conv_r,conv_g,conv_b} into dst_wdata on that cycle, and go to WRn.
REQ-014 WRn SHALL assert dst_wr with dst_addr = dst_base + 2*index + n (mod 2^16), holding dst_wr, dst_addr and dst_wdata stable until dst_ready=1.
REQ-015 On acceptance, WR0 SHALL go to CONV1; WR1 SHALL increment index and go to RD if index+1 < word count, else go to DONE.
REQ-016 DONE SHALL pulse done=1 for 1 cycle and return to IDLE.
REQ-017 Minimum latency per word SHALL be 8 cycles (RD, RDW, CONV0, WAIT0, WR0, CONV1, WAIT1, WR1) with conv_ready arriving 1 cycle after conv_start and dst_ready=1.
REQ-018 abort=1 in any busy state SHALL return the FSM to IDLE on the next edge, drop src_rd, conv_start and dst_wr, and produce no done pulse; abort SHALL take priority over all other transitions.
REQ-019 conv_ready=1 outside the WAIT states SHALL be ignored.
REQ-020 A num_pixels of 0xFFFE SHALL produce 0x7FFF words with no counter overflow.

Reset
REQ-021 While rst_n=0, the FSM SHALL be IDLE and every output SHALL be 0 (busy, done, err, src_rd, src_addr, conv_start, conv_y, conv_u, conv_v, dst_wr, dst_addr, dst_wdata).
REQ-022 A reset during a job SHALL abandon the job; after release the block SHALL accept a new start.

Verification
REQ-023 num_pixels=2, src_base=0x0010, dst_base=0x0100, word 0x80FF8000 -> one read at 0x0010; writes 0x000000 at 0x0100 and 0xFFFFFF at 0x0101; done 1 cycle after the second accept; total 9 cycles from start.
REQ-024 num_pixels=3 -> err pulse, busy stays 0, no src_rd; num_pixels=0 -> same result.
REQ-025 num_pixels=4, dst_ready held 0 for 5 cycles in WR0 -> dst_wr, dst_addr and dst_wdata stable for those 5 cycles, then exactly 4 writes at dst_base+0..3.
REQ-026 abort asserted in WAIT1 of word 0 with num_pixels=4 -> next cycle busy=0, no further write, no done; a following start with num_pixels=2 completes normally.
REQ-027 rst_n pulsed low in WR0 -> all outputs 0 immediately; conv_ready pulse in IDLE -> no output change.
REQ-028 src_base=0xFFFF, num_pixels=4 -> read addresses 0xFFFF then 0x0000.
